// File: rtl/cascade_mod_counter.sv
// Cascaded modulo-RADIX up/down counter with clamped parallel load, wrap tick and zero flag.
// Optional enable prescaler is compiled in when PRESCALER_EN is defined.
module cascade_mod_counter #(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter int W        = 4,
    parameter int PRESCALE = 50000000,
    parameter int PW       = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] count,
    output logic                tick,
    output logic                zero
);

    localparam int CW = DIGITS * W;
    localparam logic [W-1:0] MAX_DIGIT = W'(RADIX - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          step;
    logic [W-1:0]  dig;
    logic          chain;

`ifdef PRESCALER_EN
    logic [PW-1:0] presc_q, presc_d;

    assign step = en && (presc_q == PW'(PRESCALE - 1));
`else
    logic unused_cfg;

    assign step       = en;
    assign unused_cfg = ^{32'(PRESCALE), 32'(PW)};
`endif

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        dig     = '0;
        chain   = 1'b1;
`ifdef PRESCALER_EN
        presc_d = presc_q;
`endif
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = load_val[i*W +: W];
                count_d[i*W +: W] = (dig > MAX_DIGIT) ? MAX_DIGIT : dig;
            end
`ifdef PRESCALER_EN
            presc_d = '0;
`endif
        end else if (step) begin
            // chain stays high while every lower digit sits at its wrap value
            for (int i = 0; i < DIGITS; i++) begin
                dig = count_q[i*W +: W];
                if (chain) begin
                    if (up) begin
                        count_d[i*W +: W] = (dig == MAX_DIGIT) ? '0 : dig + W'(1);
                    end else begin
                        count_d[i*W +: W] = (dig == '0) ? MAX_DIGIT : dig - W'(1);
                    end
                end
                chain = chain & (up ? (dig == MAX_DIGIT) : (dig == '0));
            end
            tick_d = chain;
`ifdef PRESCALER_EN
            presc_d = '0;
`endif
        end else if (en) begin
`ifdef PRESCALER_EN
            presc_d = presc_q + PW'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
`ifdef PRESCALER_EN
            presc_q <= '0;
`endif
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
`ifdef PRESCALER_EN
            presc_q <= presc_d;
`endif
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Bench for cascade_mod_counter: integer-valued reference model plus directed literal checks
// and a randomized phase. Follows PRESCALER_EN the same way the design does.
module tb_cascade_mod_counter;

    localparam int DIGITS   = 2;
    localparam int RADIX    = 10;
    localparam int W        = 4;
    localparam int PRESCALE = 4;
    localparam int PW       = 2;
    localparam int CW       = DIGITS * W;
    localparam int N        = RADIX ** DIGITS;
`ifdef PRESCALER_EN
    localparam int STEP_CYC = PRESCALE;
`else
    localparam int STEP_CYC = 1;
`endif

    logic          clk;
    logic          reset;
    logic          en;
    logic          up;
    logic          load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tick;
    logic          zero;

    int n_tests;
    int n_fail;

    cascade_mod_counter #(
        .DIGITS(DIGITS), .RADIX(RADIX), .W(W), .PRESCALE(PRESCALE), .PW(PW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .zero(zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: the whole counter is one integer modulo RADIX**DIGITS
    function automatic logic [CW-1:0] to_digits(input int v);
        logic [CW-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*W +: W] = W'(x % RADIX);
            x = x / RADIX;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [CW-1:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(lv[i*W +: W]);
            if (d >= RADIX) d = RADIX - 1;
            v = v * RADIX + d;
        end
        return v;
    endfunction

    int   m_val;
    int   m_presc;
    logic m_tick;
    logic m_step;
    logic [CW+1:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_val = 0; m_tick = 1'b0; m_presc = 0;
        end else if (load) begin
            m_val = from_load(load_val); m_tick = 1'b0; m_presc = 0;
        end else begin
            m_tick = 1'b0;
            m_step = en;
`ifdef PRESCALER_EN
            if (en) begin
                if (m_presc == PRESCALE - 1) m_presc = 0;
                else begin
                    m_presc = m_presc + 1;
                    m_step  = 1'b0;
                end
            end
`endif
            if (m_step) begin
                if (up) begin
                    if (m_val == N - 1) begin m_val = 0; m_tick = 1'b1; end
                    else m_val = m_val + 1;
                end else begin
                    if (m_val == 0) begin m_val = N - 1; m_tick = 1'b1; end
                    else m_val = m_val - 1;
                end
            end
        end
        exp_q.push_back({(m_val == 0), m_tick, to_digits(m_val)});
    end

    // scoreboard
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [CW+1:0] sb_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            check("model {zero,tick,count}", 64'({zero, tick, count}), 64'(sb_e));
        end
    end

    // driver tasks
    task automatic drive(input logic r, input logic l, input logic e, input logic u,
                         input logic [CW-1:0] lv);
        reset = r; load = l; en = e; up = u; load_val = lv;
        @(negedge clk);
    endtask

    task automatic do_step(input logic u);
        repeat (STEP_CYC) drive(1'b0, 1'b0, 1'b1, u, '0);
    endtask

    task automatic do_load(input logic [CW-1:0] lv);
        drive(1'b0, 1'b1, 1'b0, 1'b1, lv);
    endtask

    int tick_seen;
    logic [CW-1:0] lv_r;

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        check("reset count", 64'(count), 64'h00);
        check("reset tick", 64'(tick), 64'h0);
        check("reset zero", 64'(zero), 64'h1);

        // full up sweep
        tick_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            do_step(1'b1);
            if (tick) tick_seen++;
            if (k == 9)   check("up 9 steps", 64'(count), 64'h09);
            if (k == 10)  check("up carry", 64'(count), 64'h10);
            if (k == 99)  check("up 99 steps", 64'(count), 64'h99);
            if (k == 100) begin
                check("up wrap count", 64'(count), 64'h00);
                check("up wrap tick", 64'(tick), 64'h1);
            end
        end
        check("single tick in sweep", 64'(tick_seen), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("tick one cycle", 64'(tick), 64'h0);

        // down with borrow
        do_load(8'h10);
        check("load 0x10", 64'(count), 64'h10);
        for (int k = 1; k <= 11; k++) begin
            do_step(1'b0);
            if (k == 1)  check("down borrow", 64'(count), 64'h09);
            if (k == 10) check("down to zero", 64'(count), 64'h00);
            if (k == 10) check("no tick at zero", 64'(tick), 64'h0);
            if (k == 11) begin
                check("down wrap count", 64'(count), 64'h99);
                check("down wrap tick", 64'(tick), 64'h1);
            end
        end

        // clamped loads
        do_load(8'h3F);
        check("clamp low digit", 64'(count), 64'h39);
        do_load(8'hC2);
        check("clamp high digit", 64'(count), 64'h92);

        // simultaneous events
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h45);
        check("load over step", 64'(count), 64'h45);
        check("load tick", 64'(tick), 64'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h45);
        check("reset over load", 64'(count), 64'h00);
        do_load(8'h99);
        drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
        check("reset over wrap count", 64'(count), 64'h00);
        check("reset over wrap tick", 64'(tick), 64'h0);

        // direction and hold
        do_load(8'h09);
        do_step(1'b1);
        check("dir up", 64'(count), 64'h10);
        do_step(1'b0);
        check("dir down", 64'(count), 64'h09);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
            check("hold count", 64'(count), 64'h09);
            check("hold tick", 64'(tick), 64'h0);
        end

`ifdef PRESCALER_EN
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
            check("prescaled step", 64'(count), 64'(k / 4));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("paused prescaler no step", 64'(count), 64'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("paused prescaler step", 64'(count), 64'h01);
`endif

        // randomized phase, biased toward wrap points
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0: lv_r = 8'h99;
                1: lv_r = 8'h00;
                default: lv_r = CW'($urandom);
            endcase
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) != 0, 1'($urandom), lv_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
